// File: rtl/controle_elevador.sv
// Four-floor elevator controller: call latching, directional sweep, door dwell, occupancy count.
// Latency: a call at the current floor opens the door on the next edge; movement starts on the next edge.
// Backpressure: none; calls are level/pulse sampled every cycle, entra/sai only counted with the door open.
module controle_elevador #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6,
  parameter int MAX_PESSOAS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] chamada,
  input  logic       entra,
  input  logic       sai,
  output logic [1:0] andar,
  output logic [2:0] pessoas,
  output logic       porta_aberta,
  output logic       subindo,
  output logic       descendo,
  output logic       excesso,
  output logic [3:0] pendentes
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA} estado_t;

  estado_t       estado, prox_estado;
  logic          dir;
  logic [TW-1:0] timer;

  logic [3:0] pend_eff;
  logic [3:0] mascara_acima, mascara_abaixo;
  logic [3:0] acima, abaixo;
  logic       tem_acima, tem_abaixo;
  logic       chamada_aqui, pend_aqui;
  logic [1:0] andar_prox;
  logic       fim_viagem, fim_porta, fim_curso;
  logic [3:0] bit_andar, bit_prox;

  // Pending calls including this cycle's buttons, split into above/below the car
  always_comb begin
    pend_eff       = pendentes | chamada;
    mascara_acima  = 4'b1110 << andar;
    mascara_abaixo = ~(4'b1111 << andar);
    acima          = pend_eff & mascara_acima;
    abaixo         = pend_eff & mascara_abaixo;
    tem_acima      = |acima;
    tem_abaixo     = |abaixo;
    chamada_aqui   = chamada[andar];
    pend_aqui      = pend_eff[andar];
    andar_prox     = (estado == SUBINDO) ? andar + 2'd1 : andar - 2'd1;
    fim_viagem     = (timer == TW'(TRAVEL_CYCLES - 1));
    fim_porta      = (timer == TW'(DOOR_CYCLES - 1));
    // Arriving at an end floor with nothing there would mean nowhere left to go
    fim_curso      = ((estado == SUBINDO) && (andar_prox == 2'd3)) ||
                     ((estado == DESCENDO) && (andar_prox == 2'd0));
    bit_andar      = 4'b0001 << andar;
    bit_prox       = 4'b0001 << andar_prox;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= PARADO;
    else     estado <= prox_estado;
  end

  // Next-state: directional sweep, door hold while over capacity
  always_comb begin
    prox_estado = estado;
    case (estado)
      PARADO: begin
        if (pend_aqui)                    prox_estado = PORTA;
        else if (tem_acima && tem_abaixo) prox_estado = dir ? SUBINDO : DESCENDO;
        else if (tem_acima)               prox_estado = SUBINDO;
        else if (tem_abaixo)              prox_estado = DESCENDO;
      end
      SUBINDO, DESCENDO: begin
        if (fim_viagem) begin
          if (pend_eff[andar_prox]) prox_estado = PORTA;
          else if (fim_curso)       prox_estado = PARADO;
        end
      end
      PORTA: begin
        // A call at this floor restarts the dwell and takes priority over leaving
        if (!chamada_aqui && fim_porta && !excesso) begin
          if (dir && tem_acima)        prox_estado = SUBINDO;
          else if (!dir && tem_abaixo) prox_estado = DESCENDO;
          else if (tem_acima)          prox_estado = SUBINDO;
          else if (tem_abaixo)         prox_estado = DESCENDO;
          else                         prox_estado = PARADO;
        end
      end
      default: prox_estado = PARADO;
    endcase
  end

  // Outputs decoded from state and occupancy
  always_comb begin
    subindo      = (estado == SUBINDO);
    descendo     = (estado == DESCENDO);
    porta_aberta = (estado == PORTA);
    excesso      = (pessoas > 3'(MAX_PESSOAS));
  end

  // Timer: travel per floor or door dwell; cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (prox_estado != estado) begin
      timer <= '0;
    end else begin
      case (estado)
        SUBINDO, DESCENDO: timer <= fim_viagem ? '0 : timer + TW'(1);
        PORTA: begin
          if (chamada_aqui)   timer <= '0;
          else if (fim_porta) timer <= timer;
          else                timer <= timer + TW'(1);
        end
        default: timer <= '0;
      endcase
    end
  end

  // Floor position and remembered sweep direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      andar <= 2'd0;
      dir   <= 1'b1;
    end else begin
      if ((estado == SUBINDO || estado == DESCENDO) && fim_viagem) andar <= andar_prox;
      if (prox_estado == SUBINDO)       dir <= 1'b1;
      else if (prox_estado == DESCENDO) dir <= 1'b0;
    end
  end

  // Call register: latch buttons, drop the floor being served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendentes <= 4'b0000;
    end else begin
      if (estado == PARADO || estado == PORTA)
        pendentes <= pend_eff & ~bit_andar;
      else if (fim_viagem && prox_estado == PORTA)
        pendentes <= pend_eff & ~bit_prox;
      else
        pendentes <= pend_eff;
    end
  end

  // Occupancy: counted only with the door open, saturating at 0 and 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pessoas <= 3'd0;
    end else if (estado == PORTA) begin
      if (entra && !sai && pessoas != 3'd7)      pessoas <= pessoas + 3'd1;
      else if (sai && !entra && pessoas != 3'd0) pessoas <= pessoas - 3'd1;
    end
  end

endmodule

// File: tb/tb_controle_elevador.sv
// Directed bench for controle_elevador with a cycle-tagged scoreboard.
// Stimulus pushes expected output snapshots; a negedge monitor pops and compares them.
module tb_controle_elevador;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] chamada;
  logic       entra, sai;
  logic [1:0] andar;
  logic [2:0] pessoas;
  logic       porta_aberta, subindo, descendo, excesso;
  logic [3:0] pendentes;

  controle_elevador #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(6), .MAX_PESSOAS(5)) dut (
    .clk(clk), .rst(rst), .chamada(chamada), .entra(entra), .sai(sai),
    .andar(andar), .pessoas(pessoas), .porta_aberta(porta_aberta),
    .subindo(subindo), .descendo(descendo), .excesso(excesso), .pendentes(pendentes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [12:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  logic [12:0] obs;
  assign obs = {andar, pessoas, porta_aberta, subindo, descendo, excesso, pendentes};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every snapshot due at this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc != cyc || obs !== mon_e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d got {andar,pes,porta,sub,desc,exc,pend}=%b_%b_%b%b%b%b_%b required %b_%b_%b_%b",
                 mon_e.nm, cyc, mon_e.cyc, andar, pessoas, porta_aberta, subindo, descendo,
                 excesso, pendentes, mon_e.exp[12:11], mon_e.exp[10:8], mon_e.exp[7:4], mon_e.exp[3:0]);
      end
    end
  end

  // flags = {porta, sub, desc, exc}; snapshot due k edges after the current negedge
  task automatic exp_at(input int k, input string nm, input logic [1:0] a, input logic [2:0] p,
                        input logic [3:0] flags, input logic [3:0] pend);
    exp_t e;
    int   i;
    e.cyc = cyc + k;
    e.exp = {a, p, flags, pend};
    e.nm  = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_PORTA = 4'b1000;
  localparam logic [3:0] F_SUB = 4'b0100;
  localparam logic [3:0] F_DESC = 4'b0010;
  localparam logic [3:0] F_PORTA_EXC = 4'b1001;

  initial begin
    rst = 1'b1; chamada = 4'b0000; entra = 1'b0; sai = 1'b0;

    // Reset state
    step(1);
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL rst_direct got %b", obs);
    end
    exp_at(1, "rst_hold", 2'd0, 3'd0, F_NONE, 4'b0000);
    step(1);
    rst = 1'b0;
    exp_at(1, "rst_idle", 2'd0, 3'd0, F_NONE, 4'b0000);
    exp_at(3, "idle_no_call", 2'd0, 3'd0, F_NONE, 4'b0000);
    step(4);

    // Call to floor 3 from floor 0
    chamada = 4'b1000;
    exp_at(1,  "a_go",        2'd0, 3'd0, F_SUB,   4'b1000);
    exp_at(8,  "a_pre_f1",    2'd0, 3'd0, F_SUB,   4'b1000);
    exp_at(9,  "a_f1",        2'd1, 3'd0, F_SUB,   4'b1000);
    exp_at(17, "a_f2",        2'd2, 3'd0, F_SUB,   4'b1000);
    exp_at(25, "a_f3_door",   2'd3, 3'd0, F_PORTA, 4'b0000);
    exp_at(30, "a_door_last", 2'd3, 3'd0, F_PORTA, 4'b0000);
    exp_at(31, "a_idle",      2'd3, 3'd0, F_NONE,  4'b0000);
    step(1); chamada = 4'b0000; step(31);

    // Back down to floor 0
    chamada = 4'b0001;
    exp_at(1,  "r_go",   2'd3, 3'd0, F_DESC,  4'b0001);
    exp_at(17, "r_f1",   2'd1, 3'd0, F_DESC,  4'b0001);
    exp_at(25, "r_f0",   2'd0, 3'd0, F_PORTA, 4'b0000);
    exp_at(31, "r_idle", 2'd0, 3'd0, F_NONE,  4'b0000);
    step(1); chamada = 4'b0000; step(31);

    // Call at current floor, then restart dwell mid-way
    chamada = 4'b0001;
    exp_at(1, "b_open", 2'd0, 3'd0, F_PORTA, 4'b0000);
    step(1); chamada = 4'b0000; step(2);
    chamada = 4'b0001;
    exp_at(1, "b_restart", 2'd0, 3'd0, F_PORTA, 4'b0000);
    exp_at(4, "b_held",    2'd0, 3'd0, F_PORTA, 4'b0000);
    exp_at(6, "b_last",    2'd0, 3'd0, F_PORTA, 4'b0000);
    exp_at(7, "b_close",   2'd0, 3'd0, F_NONE,  4'b0000);
    step(1); chamada = 4'b0000; step(9);

    // Calls at 1 and 3 from floor 0, call at 0 raised while stopped at 1
    chamada = 4'b1010;
    exp_at(1, "d_go",    2'd0, 3'd0, F_SUB,   4'b1010);
    exp_at(9, "d_stop1", 2'd1, 3'd0, F_PORTA, 4'b1000);
    step(1); chamada = 4'b0000; step(9);
    chamada = 4'b0001;
    exp_at(1,  "d_call0",  2'd1, 3'd0, F_PORTA, 4'b1001);
    exp_at(5,  "d_leave1", 2'd1, 3'd0, F_SUB,   4'b1001);
    exp_at(21, "d_f3",     2'd3, 3'd0, F_PORTA, 4'b0001);
    exp_at(27, "d_rev",    2'd3, 3'd0, F_DESC,  4'b0001);
    exp_at(51, "d_f0",     2'd0, 3'd0, F_PORTA, 4'b0000);
    exp_at(57, "d_idle",   2'd0, 3'd0, F_NONE,  4'b0000);
    step(1); chamada = 4'b0000; step(57);

    // Over capacity holds the door, one exit releases it toward floor 2
    chamada = 4'b0001;
    exp_at(1,  "c_open",   2'd0, 3'd0, F_PORTA,     4'b0000);
    exp_at(3,  "c_pes2",   2'd0, 3'd2, F_PORTA,     4'b0000);
    exp_at(7,  "c_pes6",   2'd0, 3'd6, F_PORTA_EXC, 4'b0100);
    exp_at(12, "c_held",   2'd0, 3'd6, F_PORTA_EXC, 4'b0100);
    exp_at(14, "c_sai",    2'd0, 3'd5, F_PORTA,     4'b0100);
    exp_at(15, "c_depart", 2'd0, 3'd5, F_SUB,       4'b0100);
    exp_at(31, "c_f2",     2'd2, 3'd5, F_PORTA,     4'b0000);
    exp_at(37, "c_idle",   2'd2, 3'd5, F_NONE,      4'b0000);
    step(1); chamada = 4'b0000; entra = 1'b1;
    step(2); chamada = 4'b0001;
    step(1); chamada = 4'b0000;
    step(1); chamada = 4'b0100;
    step(1); chamada = 4'b0000;
    step(1); entra = 1'b0;
    step(6); sai = 1'b1;
    step(1); sai = 1'b0;
    step(24);

    // Occupancy saturation, simultaneous pulses, pulses with door closed
    chamada = 4'b0100;
    exp_at(1,  "e_open",         2'd2, 3'd5, F_PORTA,     4'b0000);
    exp_at(2,  "e_pes6",         2'd2, 3'd6, F_PORTA_EXC, 4'b0000);
    exp_at(3,  "e_pes7",         2'd2, 3'd7, F_PORTA_EXC, 4'b0000);
    exp_at(4,  "e_max",          2'd2, 3'd7, F_PORTA_EXC, 4'b0000);
    exp_at(11, "e_pes0",         2'd2, 3'd0, F_PORTA,     4'b0000);
    exp_at(12, "e_min",          2'd2, 3'd0, F_PORTA,     4'b0000);
    exp_at(15, "e_pes3",         2'd2, 3'd3, F_PORTA,     4'b0000);
    exp_at(16, "e_both",         2'd2, 3'd3, F_PORTA,     4'b0000);
    exp_at(21, "e_last_open",    2'd2, 3'd3, F_PORTA,     4'b0000);
    exp_at(22, "e_closed",       2'd2, 3'd3, F_NONE,      4'b0000);
    exp_at(24, "e_entra_closed", 2'd2, 3'd3, F_NONE,      4'b0000);
    exp_at(25, "e_sai_closed",   2'd2, 3'd3, F_NONE,      4'b0000);
    step(1); entra = 1'b1;
    step(3); entra = 1'b0; sai = 1'b1;
    step(8); sai = 1'b0; entra = 1'b1;
    step(3); entra = 1'b1; sai = 1'b1;
    step(1); entra = 1'b0; sai = 1'b0; chamada = 4'b0000;
    step(7); entra = 1'b1;
    step(1); entra = 1'b0; sai = 1'b1;
    step(1); sai = 1'b0;
    step(2);

    // Asynchronous reset while travelling from floor 2 toward 1
    chamada = 4'b0001;
    exp_at(1, "f_go", 2'd2, 3'd3, F_DESC, 4'b0001);
    step(1); chamada = 4'b0000;
    step(3);
    exp_at(1, "f_async", 2'd0, 3'd0, F_NONE, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL f_async_direct got %b", obs);
    end
    @(negedge clk);
    step(1); rst = 1'b0;
    exp_at(2,  "f_idle",  2'd0, 3'd0, F_NONE, 4'b0000);
    exp_at(10, "f_still", 2'd0, 3'd0, F_NONE, 4'b0000);
    step(12);

    checks++;
    if (pendentes !== 4'b0000 || subindo !== 1'b0 || descendo !== 1'b0 || porta_aberta !== 1'b0) begin
      errors++;
      $display("FAIL f_final got pend=%b sub=%b desc=%b porta=%b", pendentes, subindo, descendo, porta_aberta);
    end

    // Drain anything still due, bounded
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared (due cyc=%0d, now cyc=%0d)", mon_e.nm, mon_e.cyc, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_elevador.md
# controle_elevador

Four-floor elevator controller that registers floor calls, schedules car movement with a directional sweep, times door dwell and tracks cabin occupancy. It sits directly upstream of the display multiplexer. Its `andar` output drives the floor-digit inputs. Its `pessoas` output drives the occupancy-digit inputs (`andar[1]`→A, `andar[0]`→B; `pessoas[2]`→C, `pessoas[1]`→D, `pessoas[0]`→E).

## Interface
- `TRAVEL_CYCLES`, 8: clock cycles to move one floor (≥2).
- `DOOR_CYCLES`, 6: clock cycles the door stays open per service (≥2).
- `MAX_PESSOAS`, 5: highest occupancy allowed to depart (≤6).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `chamada` in 4: floor-call buttons, bit i = floor i. Level or pulse; sampled every cycle.
- `entra` in 1: one-cycle pulse, one passenger enters.
- `sai` in 1: one-cycle pulse, one passenger leaves.
- `andar` out 2: current floor, 0–3.
- `pessoas` out 3: occupancy count, 0–7.
- `porta_aberta` out 1: door open.
- `subindo` out 1: car moving up.
- `descendo` out 1: car moving down.
- `excesso` out 1: `pessoas > MAX_PESSOAS`.
- `pendentes` out 4: registered outstanding calls.

## Operation
- FSM states are PARADO, SUBINDO, DESCENDO and PORTA. A `dir` register holds the last direction: 1 = up, reset value 1.
- **Call latching:** `pendentes |= chamada` each cycle. A call for the current floor sets no bit while in PORTA; it restarts the door timer instead. In PARADO, such a call moves the FSM to PORTA and sets no bit.
- **Leaving PARADO:**
  - A pending call at the current floor goes to PORTA.
  - Otherwise, calls above only go to SUBINDO. Calls below only go to DESCENDO.
  - Calls both above and below go the way `dir` points.
  - No calls: stay in PARADO.
- **Moving:** a timer counts `TRAVEL_CYCLES`. On its last cycle, `andar` steps ±1 and the timer clears.
  - If `pendentes[new floor]` is set: go to PORTA and clear that bit on the same edge.
  - Otherwise keep moving.
  - Never step past floor 0 or 3. A move only starts when a call exists in that direction.
- **PORTA:**
  - The timer counts `DOOR_CYCLES` and the pending bit for the current floor is cleared.
  - When the timer expires with `excesso` = 0: if calls exist beyond `andar` in direction `dir`, move that way. Else, if calls exist the other way, reverse and update `dir`. Else go to PARADO.
  - With `excesso` = 1 at expiry: stay in PORTA and hold the timer at expiry until `excesso` drops. Then decide on the next cycle.
- **Occupancy:** `entra`/`sai` are honoured only while `porta_aberta` = 1.
  - `entra` at 7 is ignored. `sai` at 0 is ignored.
  - `entra` and `sai` in the same cycle leave the count unchanged.
- Output decoding:
  - `subindo` = state SUBINDO.
  - `descendo` = state DESCENDO.
  - `porta_aberta` = state PORTA.
  - `excesso` is combinational from `pessoas`.

## Timing
- Reset values: state PARADO, `andar`=0, `pessoas`=0, `pendentes`=0, all timers 0, `dir`=up. All outputs are therefore 0 during and after reset.
- Reset mid-travel or with the door open aborts immediately. Calls and occupancy are lost.
- Call-to-door at the current floor from PARADO: PORTA one cycle after `chamada` is sampled.
- Call one floor away from PARADO:
  - Cycle 1 after the call: `subindo`/`descendo` asserts.
  - `andar` updates `TRAVEL_CYCLES` cycles later.
  - `porta_aberta` asserts on that same edge.
- The door stays open for exactly `DOOR_CYCLES` cycles, counted from the edge it opened or last restarted.
- An `entra`/`sai` pulse is reflected in `pessoas` on the next edge.

## Test plan
- Reset, then `chamada`=4'b1000 for 1 cycle → `subindo`=1. `andar` passes 1, 2, 3 at 8-cycle intervals. `porta_aberta`=1 for 6 cycles at floor 3, then PARADO with `pendentes`=0.
- At floor 0, `chamada`=4'b0001 → `porta_aberta`=1 next cycle, `andar` stays 0. Repeat the call mid-dwell → door held 6 more cycles.
- Door open at floor 0, six `entra` pulses → `pessoas`=6, `excesso`=1, door stays open past 6 cycles. One `sai` → `pessoas`=5, car departs toward the pending call.
- Car rising from 0 with calls at 3 and 1 → stops at 1 (door), then continues to 3. A call at 0 raised meanwhile is served only after 3 (reversal, `dir`=down).
- With `pessoas`=7, `entra` → stays 7. With `pessoas`=0, `sai` → stays 0. `entra`+`sai` together at 3 → stays 3. Pulses with the door closed → no change.
- Assert `rst` while moving between floors 1 and 2 → all outputs 0 asynchronously, no movement after release until a new call.
